// File: rtl/snes_pkg.sv
// Shared constants, state encoding and frame packing for the SNES pad responder.
package snes_pkg;

    localparam int SNES_FRAME_BITS  = 16;
    localparam int SNES_BUTTON_BITS = 12;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } snes_state_t;

    // Active-low wire frame; the four trailing ID bits always read as released.
    function automatic logic [SNES_FRAME_BITS-1:0] snes_frame(
        input logic [SNES_BUTTON_BITS-1:0] buttons
    );
        logic [SNES_FRAME_BITS-1:0] f;
        f              = 16'hFFFF;
        f[BTN_B]       = ~buttons[BTN_B];
        f[BTN_Y]       = ~buttons[BTN_Y];
        f[BTN_SELECT]  = ~buttons[BTN_SELECT];
        f[BTN_START]   = ~buttons[BTN_START];
        f[BTN_UP]      = ~buttons[BTN_UP];
        f[BTN_DOWN]    = ~buttons[BTN_DOWN];
        f[BTN_LEFT]    = ~buttons[BTN_LEFT];
        f[BTN_RIGHT]   = ~buttons[BTN_RIGHT];
        f[BTN_A]       = ~buttons[BTN_A];
        f[BTN_X]       = ~buttons[BTN_X];
        f[BTN_L]       = ~buttons[BTN_L];
        f[BTN_R]       = ~buttons[BTN_R];
        return f;
    endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by registered edge pulses.
module snes_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic core_clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // Synchronizer chain, previous-level flop and edge pulses.
    always_ff @(posedge core_clock) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/snes_controller_responder.sv
// Device end of the SNES joypad protocol: answers latch/clock with a 16-bit
// active-low serial button frame.
module snes_controller_responder
    import snes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        core_clock,
    input  logic        reset,
    input  logic [11:0] i_buttons,
    input  logic        i_controller_latch,
    input  logic        i_controller_clock,
    output logic        o_controller_data,
    output logic        o_frame_done,
    output logic        o_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic w_latch_level, w_latch_rise, w_latch_fall;
    logic w_clk_level, w_clk_rise, w_clk_fall;
    logic w_unused_clk;

    snes_state_t                r_state;
    logic [SNES_FRAME_BITS-1:0] r_shift;
    logic [4:0]                 r_bit_count;
    logic [TW-1:0]              r_timeout;
    logic                       r_data;
    logic                       r_frame_done;
    logic                       r_busy;

    snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
        .core_clock (core_clock),
        .reset      (reset),
        .i_pin      (i_controller_latch),
        .o_level    (w_latch_level),
        .o_rise     (w_latch_rise),
        .o_fall     (w_latch_fall)
    );

    // The shift clock idles high, so its synchronizer resets high to avoid a false edge.
    snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clock_sync (
        .core_clock (core_clock),
        .reset      (reset),
        .i_pin      (i_controller_clock),
        .o_level    (w_clk_level),
        .o_rise     (w_clk_rise),
        .o_fall     (w_clk_fall)
    );

    assign w_unused_clk = w_clk_level ^ w_clk_fall;

    // Protocol FSM with shift register, bit counter, timeout and registered outputs.
    always_ff @(posedge core_clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= 16'hFFFF;
            r_bit_count  <= 5'd0;
            r_timeout    <= {TW{1'b0}};
            r_data       <= 1'b1;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_latch_rise) begin
                // A new latch always restarts the frame, even mid-shift.
                r_state     <= ST_LOAD;
                r_shift     <= snes_frame(i_buttons);
                r_data      <= ~i_buttons[BTN_B];
                r_bit_count <= 5'd0;
                r_timeout   <= {TW{1'b0}};
                r_busy      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_data <= 1'b1;
                        if (w_latch_level) begin
                            r_state <= ST_LOAD;
                            r_shift <= snes_frame(i_buttons);
                            r_data  <= ~i_buttons[BTN_B];
                            r_busy  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        r_shift <= snes_frame(i_buttons);
                        r_data  <= ~i_buttons[BTN_B];
                        r_busy  <= 1'b1;
                        if (w_latch_fall) begin
                            r_state     <= ST_SHIFT;
                            r_bit_count <= 5'd0;
                            r_timeout   <= {TW{1'b0}};
                        end else begin
                            r_state     <= ST_LOAD;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_clk_rise) begin
                            r_shift     <= {1'b0, r_shift[SNES_FRAME_BITS-1:1]};
                            r_bit_count <= (r_bit_count == 5'd16) ? 5'd16 : r_bit_count + 5'd1;
                            r_timeout   <= {TW{1'b0}};
                            if (r_bit_count == 5'd15) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                                r_data       <= 1'b0;
                                r_busy       <= 1'b0;
                            end else begin
                                r_data       <= r_shift[1];
                                r_busy       <= 1'b1;
                            end
                        end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                            r_state <= ST_IDLE;
                            r_data  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_timeout <= r_timeout + {{(TW-1){1'b0}}, 1'b1};
                            r_data    <= r_shift[0];
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_data <= 1'b0;
                        r_busy <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_data  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_controller_data = r_data;
    assign o_frame_done      = r_frame_done;
    assign o_busy            = r_busy;

endmodule
